// File: rtl/auto_player_pkg.sv
// rtl/auto_player_pkg.sv - shared types and constants for the tug-of-war auto player
package auto_player_pkg;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        COOLDOWN = 2'd1,
        FROZEN   = 2'd2
    } state_t;

    // Feedback taps for x^10 + x^7 + 1 (bits 9 and 6 of the shift register)
    localparam logic [9:0] LFSR_TAPS = 10'b1001000000;

    localparam logic [8:0] CENTER = 9'b000010000;

    function automatic logic is_onehot9(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

endpackage

// File: rtl/auto_player_lfsr10.sv
// rtl/auto_player_lfsr10.sv - 10-bit Fibonacci LFSR, advances every clock
module lfsr10
    import auto_player_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] seed,
    output logic [9:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= seed;
        end else begin
            q <= {q[8:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/auto_player.sv
// rtl/auto_player.sv - autonomous tug-of-war opponent issuing rate-limited press pulses
// Optional feature: AUTO_PLAYER_PANIC_EN (boosted skill and shorter cooldown near the losing edge)
module auto_player
    import auto_player_pkg::*;
#(
    parameter int         SIDE = 0,
    parameter int         DIV  = 32768,
    parameter int         HOLD = 3,
    parameter logic [9:0] SEED = 10'h2A5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] skill,
    input  logic [8:0] field,
    input  logic       win_any,
    output logic       press,
    output logic       frozen
);

    localparam int PW = $clog2(DIV);
    localparam int CW = $clog2(HOLD + 1);
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] HOLD_CD       = CW'(HOLD);
    localparam int            PANIC_HOLD    = ((HOLD >> 1) < 1) ? 1 : (HOLD >> 1);
    localparam logic [CW-1:0] PANIC_CD      = CW'(PANIC_HOLD);
    localparam logic [8:0]    LOSE_MASK     = (SIDE == 0) ? 9'b000000011 : 9'b110000000;

    state_t        state, state_next;
    logic [PW-1:0] prescale;
    logic [CW-1:0] cooldown, cooldown_next;
    logic          press_next;
    logic          tick;
    logic          field_ok;
    logic [9:0]    lfsr_q;
    logic [8:0]    threshold;
    logic [CW-1:0] reload;

    lfsr10 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    assign tick     = (prescale == PRESCALE_LAST);
    assign field_ok = is_onehot9(field);

`ifdef AUTO_PLAYER_PANIC_EN
    logic       panic;
    logic [9:0] skill_x2;
    logic       unused_cfg;

    assign panic     = |(field & LOSE_MASK);
    assign skill_x2  = {skill, 1'b0};
    assign threshold = !panic ? skill : (skill_x2[9] ? 9'h1FF : skill_x2[8:0]);
    assign reload    = panic ? PANIC_CD : HOLD_CD;
    assign unused_cfg = lfsr_q[9];
`else
    logic unused_cfg;

    assign threshold  = skill;
    assign reload     = HOLD_CD;
    assign unused_cfg = ^{lfsr_q[9], LOSE_MASK, PANIC_CD};
`endif

    always_comb begin
        state_next    = state;
        cooldown_next = cooldown;
        press_next    = 1'b0;
        unique case (state)
            ARMED: begin
                if (win_any) begin
                    state_next = FROZEN;
                end else if (tick && field_ok && (threshold > lfsr_q[8:0])) begin
                    press_next    = 1'b1;
                    cooldown_next = reload;
                    state_next    = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (win_any) begin
                    state_next = FROZEN;
                end else if (tick) begin
                    // The tick that empties the cooldown only re-arms; it cannot press
                    cooldown_next = cooldown - CW'(1);
                    if (cooldown == CW'(1)) begin
                        state_next = ARMED;
                    end
                end
            end
            FROZEN: begin
                cooldown_next = '0;
                if ((field == CENTER) && !win_any) begin
                    state_next = ARMED;
                end
            end
            default: begin
                state_next    = ARMED;
                cooldown_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARMED;
            prescale <= '0;
            cooldown <= '0;
            press    <= 1'b0;
            frozen   <= 1'b0;
        end else begin
            state    <= state_next;
            prescale <= tick ? '0 : prescale + PW'(1);
            cooldown <= cooldown_next;
            press    <= press_next;
            frozen   <= (state_next == FROZEN);
        end
    end

endmodule

// File: tb/tb_auto_player.sv
// tb/tb_auto_player.sv - directed self-checking bench for auto_player (DIV=4, HOLD=2)
module tb_auto_player;

    localparam int         SIDE = 0;
    localparam int         DIV  = 4;
    localparam int         HOLD = 2;
    localparam logic [9:0] SEED = 10'h2A5;
    localparam logic [8:0] CTR  = 9'b000010000;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] skill;
    logic [8:0] field;
    logic       win_any;
    logic       press;
    logic       frozen;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [9:0] m_lfsr;
    int         m_cnt;
    int         m_cd;
    int         m_st;
    logic       m_press;
    logic       m_frozen;

    // press statistics
    int   ncyc;
    int   pcount;
    int   mcount;
    int   dbl;
    int   last;
    int   min_sp;
    logic prev_press;

    auto_player #(
        .SIDE (SIDE),
        .DIV  (DIV),
        .HOLD (HOLD),
        .SEED (SEED)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .skill   (skill),
        .field   (field),
        .win_any (win_any),
        .press   (press),
        .frozen  (frozen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_stats();
        pcount     = 0;
        mcount     = 0;
        dbl        = 0;
        last       = -1;
        min_sp     = 1000000;
        prev_press = 1'b0;
    endtask

    task automatic model_step();
        logic t, onehot, pn;
        int   thr, rl;
        if (reset) begin
            m_lfsr = SEED; m_cnt = 0; m_cd = 0; m_st = 0;
            m_press = 1'b0; m_frozen = 1'b0;
        end else begin
            t      = (m_cnt == DIV - 1);
            onehot = ($countones(field) == 1);
            thr    = skill;
            rl     = HOLD;
`ifdef AUTO_PLAYER_PANIC_EN
            if (field[1:0] != 2'b00) begin
                thr = (2 * skill > 511) ? 511 : 2 * skill;
                rl  = (HOLD / 2 < 1) ? 1 : HOLD / 2;
            end
`endif
            pn = 1'b0;
            if (m_st == 0) begin
                if (win_any) m_st = 2;
                else if (t && onehot && (thr > int'(m_lfsr[8:0]))) begin
                    pn = 1'b1; m_cd = rl; m_st = 1;
                end
            end else if (m_st == 1) begin
                if (win_any) m_st = 2;
                else if (t) begin
                    m_cd = m_cd - 1;
                    if (m_cd == 0) m_st = 0;
                end
            end else begin
                if ((field == CTR) && !win_any) m_st = 0;
            end
            m_press  = pn;
            m_frozen = (m_st == 2);
            m_lfsr   = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
            m_cnt    = t ? 0 : m_cnt + 1;
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        ncyc++;
        chk("press_model", int'(press), int'(m_press));
        chk("frozen_model", int'(frozen), int'(m_frozen));
        if (press === 1'b1) begin
            pcount++;
            if (prev_press) dbl++;
            if (last >= 0 && (ncyc - last) < min_sp) min_sp = ncyc - last;
            last = ncyc;
        end
        if (m_press) mcount++;
        prev_press = press;
    endtask

    initial begin
        int got;
        ncyc    = 0;
        reset   = 1'b1;
        skill   = 9'd511;
        field   = CTR;
        win_any = 1'b0;
        reset_stats();

        // 1: reset behaviour and first-press latency
        repeat (3) begin
            cyc();
            chk("t1_reset_press", int'(press), 0);
            chk("t1_reset_frozen", int'(frozen), 0);
        end
        reset = 1'b0;
        repeat (3) begin
            cyc();
            chk("t1_before_tick", int'(press), 0);
        end
        cyc();
        chk("t1_first_press", int'(press), 1);
        cyc();
        chk("t1_one_wide", int'(press), 0);

        // 2: skill 0 never presses
        reset = 1'b1; skill = 9'd0; cyc(); reset = 1'b0;
        reset_stats();
        repeat (2000) cyc();
        chk("t2_no_press", pcount, 0);

        // 3: skill 511
        reset = 1'b1; skill = 9'd511; cyc(); reset = 1'b0;
        reset_stats();
        repeat (2000) cyc();
        chk("t3_count_model", pcount, mcount);
        chk("t3_count_floor", int'(pcount >= 150), 1);
        chk("t3_single_wide", dbl, 0);
        chk("t3_spacing", int'(min_sp >= 12), 1);

        // 4: win during cooldown freezes until re-centred
        reset = 1'b1; cyc(); reset = 1'b0;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (press === 1'b1) begin
                got = 1;
                break;
            end
        end
        chk("t4_press_seen", got, 1);
        win_any = 1'b1;
        cyc();
        chk("t4_frozen_set", int'(frozen), 1);
        win_any = 1'b0;
        field   = 9'b100000000;
        reset_stats();
        repeat (50) cyc();
        chk("t4_frozen_no_press", pcount, 0);
        chk("t4_still_frozen", int'(frozen), 1);
        field = CTR;
        cyc();
        chk("t4_unfrozen", int'(frozen), 0);
        reset_stats();
        repeat (40) cyc();
        chk("t4_resume", int'(pcount > 0), 1);

        // 5: invalid fields suppress presses without changing state
        reset = 1'b1; cyc(); reset = 1'b0;
        field = 9'b000000000;
        reset_stats();
        repeat (100) cyc();
        chk("t5_zero_field", pcount, 0);
        chk("t5_zero_frozen", int'(frozen), 0);
        field = 9'b000000011;
        repeat (100) cyc();
        chk("t5_multi_field", pcount, 0);
        field = 9'b000000001;
        reset_stats();
        repeat (40) cyc();
        chk("t5_resume", int'(pcount > 0), 1);

        // 6: light at the losing edge
        reset = 1'b1; skill = 9'd300; field = 9'b000000001; cyc(); reset = 1'b0;
        reset_stats();
        repeat (400) cyc();
`ifdef AUTO_PLAYER_PANIC_EN
        chk("t6_panic_spacing", min_sp, 8);
`else
        chk("t6_spacing", int'(min_sp >= 12), 1);
`endif
        chk("t6_count_model", pcount, mcount);
        chk("t6_single_wide", dbl, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
